// File: rtl/vga_timing_640_480.sv
// VGA 640x480@60 raster timing: pixel-rate enable, h/v counters and sync/visible decodes.
// All outputs are decodes of the registered divider and h/v counters.
module vga_timing_640_480 #(
  parameter int unsigned DIV       = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_sclr,
  output logic       o_px_clk,
  output logic       o_hsync_en,
  output logic       o_vsync_en,
  output logic       o_haddr_en,
  output logic       o_vaddr_en,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx,
  output logic       o_vga_hs,
  output logic       o_vga_vs,
  output logic       o_frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned H_W     = 10;
  localparam int unsigned V_W     = 10;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
  localparam logic [H_W-1:0]   H_LAST       = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST       = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0]   H_VIS_END    = H_W'(H_VISIBLE);
  localparam logic [V_W-1:0]   V_VIS_END    = V_W'(V_VISIBLE);
  localparam logic [H_W-1:0]   H_SYNC_START = H_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_W-1:0]   H_SYNC_END   = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0]   V_SYNC_START = V_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_W-1:0]   V_SYNC_END   = V_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [H_W-1:0]   h_q, h_d;
  logic [V_W-1:0]   v_q, v_d;
  logic             px_c;
  logic             hsync_c, vsync_c, haddr_c, vaddr_c;

  assign px_c = (div_q == DIV_LAST);

  // Counter advance; clear overrides any pixel step on the same edge
  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (i_sclr) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else begin
      div_d = px_c ? '0 : div_q + DIV_W'(1);
      if (px_c) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + V_W'(1);
        end else begin
          h_d = h_q + H_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign hsync_c = (h_q >= H_SYNC_START) && (h_q < H_SYNC_END);
  assign vsync_c = (v_q >= V_SYNC_START) && (v_q < V_SYNC_END);
  assign haddr_c = (h_q < H_VIS_END);
  assign vaddr_c = (v_q < V_VIS_END);

  assign o_px_clk      = px_c;
  assign o_hsync_en    = hsync_c;
  assign o_vsync_en    = vsync_c;
  assign o_haddr_en    = haddr_c;
  assign o_vaddr_en    = vaddr_c;
  // Indices are zeroed outside the visible area so v >= 512 never aliases into range
  assign o_hidx        = haddr_c ? h_q : '0;
  assign o_vidx        = vaddr_c ? v_q[8:0] : '0;
  assign o_vga_hs      = ~hsync_c;
  assign o_vga_vs      = ~vsync_c;
  assign o_frame_start = px_c && (h_q == '0) && (v_q == '0);

endmodule

// File: tb/tb_vga_timing_640_480.sv
// Bench for vga_timing_640_480: full-size instance for divider/line timing, shrunk instance
// for whole-frame timing, both checked against an arithmetic raster model.
module tb_vga_timing_640_480;

  localparam int B_DIV = 4, B_HV = 640, B_HF = 16, B_HS = 96, B_HB = 48;
  localparam int B_VV = 480, B_VF = 10, B_VS = 2, B_VB = 33;
  localparam int S_DIV = 2, S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 6, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int B_HT = B_HV + B_HF + B_HS + B_HB;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;

  // {px, hsync_en, vsync_en, haddr_en, vaddr_en, hidx, vidx, vga_hs, vga_vs, frame_start}
  localparam logic [26:0] RESET_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 9'd0, 1'b1, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclr_b = 1'b0, sclr_s = 1'b0;
  logic       b_px, b_hse, b_vse, b_ha, b_va, b_hs, b_vs, b_fs;
  logic [9:0] b_hidx;
  logic [8:0] b_vidx;
  logic       s_px, s_hse, s_vse, s_ha, s_va, s_hs, s_vs, s_fs;
  logic [9:0] s_hidx;
  logic [8:0] s_vidx;
  logic [26:0] act_b, act_s;

  int checks = 0;
  int errors = 0;
  int n_b = 0;
  int n_s = 0;

  always #5 clk = ~clk;

  vga_timing_640_480 u_big (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr_b),
    .o_px_clk(b_px), .o_hsync_en(b_hse), .o_vsync_en(b_vse),
    .o_haddr_en(b_ha), .o_vaddr_en(b_va), .o_hidx(b_hidx), .o_vidx(b_vidx),
    .o_vga_hs(b_hs), .o_vga_vs(b_vs), .o_frame_start(b_fs)
  );

  vga_timing_640_480 #(
    .DIV(S_DIV), .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) u_small (
    .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr_s),
    .o_px_clk(s_px), .o_hsync_en(s_hse), .o_vsync_en(s_vse),
    .o_haddr_en(s_ha), .o_vaddr_en(s_va), .o_hidx(s_hidx), .o_vidx(s_vidx),
    .o_vga_hs(s_hs), .o_vga_vs(s_vs), .o_frame_start(s_fs)
  );

  assign act_b = {b_px, b_hse, b_vse, b_ha, b_va, b_hidx, b_vidx, b_hs, b_vs, b_fs};
  assign act_s = {s_px, s_hse, s_vse, s_ha, s_va, s_hidx, s_vidx, s_hs, s_vs, s_fs};

  // Model state: number of system clocks since the last reset/clear
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_b <= 0;
      n_s <= 0;
    end else begin
      n_b <= sclr_b ? 0 : n_b + 1;
      n_s <= sclr_s ? 0 : n_s + 1;
    end
  end

  function automatic logic [26:0] exp_vec(input int n, input int dv, input int hv, input int hf,
                                          input int hs, input int hb, input int vv, input int vf,
                                          input int vs, input int vb);
    int ht, vt, d, p, h, v;
    logic px, hse, vse, ha, va, fs;
    logic [9:0] hi;
    logic [8:0] vi;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    d   = n % dv;
    p   = n / dv;
    h   = p % ht;
    v   = (p / ht) % vt;
    px  = (d == dv - 1);
    hse = (h >= hv + hf) && (h < hv + hf + hs);
    vse = (v >= vv + vf) && (v < vv + vf + vs);
    ha  = (h < hv);
    va  = (v < vv);
    hi  = ha ? 10'(h) : 10'd0;
    vi  = va ? 9'(v) : 9'd0;
    fs  = px && (h == 0) && (v == 0);
    return {px, hse, vse, ha, va, hi, vi, ~hse, ~vse, fs};
  endfunction

  function automatic logic [26:0] exp_b(input int n);
    return exp_vec(n, B_DIV, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB);
  endfunction

  function automatic logic [26:0] exp_s(input int n);
    return exp_vec(n, S_DIV, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
  endfunction

  function automatic int h_of_b(input int n);
    return (n / B_DIV) % B_HT;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sclr_b = 1'b0;
    sclr_s = 1'b0;
    repeat (3) tick();
    checks++;
    if (act_b !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_big: got %h expected %h", act_b, RESET_VEC);
    end
    checks++;
    if (act_s !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_small: got %h expected %h", act_s, RESET_VEC);
    end
    #3 rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      checks++;
      if (b_px !== ((k % 4) == 3) || b_hidx !== 10'(k / 4)) begin
        errors++;
        $display("FAIL divider clk%0d: got px=%b hidx=%0d expected px=%b hidx=%0d",
                 k, b_px, b_hidx, ((k % 4) == 3), k / 4);
      end
      if (k == 3) begin
        checks++;
        if (b_fs !== 1'b1) begin
          errors++;
          $display("FAIL first_frame_start: got %b expected 1", b_fs);
        end
      end
    end
  endtask

  task automatic test_line_timing();
    int hs_cnt = 0;
    int ha_cnt = 0;
    for (int k = 0; k < 2 * B_HT * B_DIV; k++) begin
      tick();
      if (b_hse) hs_cnt++;
      if (b_ha) ha_cnt++;
      checks++;
      if (act_b !== exp_b(n_b)) begin
        errors++;
        $display("FAIL line_big n=%0d: got %h expected %h", n_b, act_b, exp_b(n_b));
      end
    end
    checks++;
    if (hs_cnt !== 2 * B_HS * B_DIV) begin
      errors++;
      $display("FAIL hsync_width: got %0d expected %0d", hs_cnt, 2 * B_HS * B_DIV);
    end
    checks++;
    if (ha_cnt !== 2 * B_HV * B_DIV) begin
      errors++;
      $display("FAIL haddr_width: got %0d expected %0d", ha_cnt, 2 * B_HV * B_DIV);
    end
  endtask

  task automatic test_frame_timing();
    int frame_clks = S_HT * S_VT * S_DIV;
    int vs_cnt = 0;
    int last_fs = -1;
    int fs_seen = 0;
    for (int k = 0; k < 4 * frame_clks; k++) begin
      tick();
      if (k < 3 * frame_clks && s_vse) vs_cnt++;
      checks++;
      if (act_s !== exp_s(n_s)) begin
        errors++;
        $display("FAIL frame_small n=%0d: got %h expected %h", n_s, act_s, exp_s(n_s));
      end
      if (s_fs) begin
        if (last_fs >= 0) begin
          checks++;
          if (k - last_fs !== frame_clks) begin
            errors++;
            $display("FAIL frame_period: got %0d expected %0d", k - last_fs, frame_clks);
          end
        end
        last_fs = k;
        fs_seen++;
      end
    end
    checks++;
    if (fs_seen < 3) begin
      errors++;
      $display("FAIL frame_pulses: got %0d expected at least 3", fs_seen);
    end
    checks++;
    if (vs_cnt !== 3 * S_VS * S_HT * S_DIV) begin
      errors++;
      $display("FAIL vsync_width: got %0d expected %0d", vs_cnt, 3 * S_VS * S_HT * S_DIV);
    end
  endtask

  task automatic test_sclr();
    int k = 0;
    while (h_of_b(n_b) != 300 && k < 4000) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 4000) begin
      errors++;
      $display("FAIL sclr_wait: got timeout expected h=300");
    end
    sclr_b = 1'b1;
    tick();
    sclr_b = 1'b0;
    checks++;
    if (act_b !== RESET_VEC) begin
      errors++;
      $display("FAIL sclr_clear: got %h expected %h", act_b, RESET_VEC);
    end
    k = 0;
    while (k < 10) begin
      tick();
      k++;
      if (b_fs) break;
    end
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL sclr_frame_start: got %0d clks expected 3", k);
    end
  endtask

  task automatic test_async_reset();
    int k = 0;
    while (h_of_b(n_b) != 700 && k < 4000) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 4000) begin
      errors++;
      $display("FAIL areset_wait: got timeout expected h=700");
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (act_b !== RESET_VEC || act_s !== RESET_VEC) begin
      errors++;
      $display("FAIL areset_immediate: got %h/%h expected %h", act_b, act_s, RESET_VEC);
    end
    tick();
    tick();
    #3 rst_n = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++;
      if (act_b !== exp_b(j) || act_s !== exp_s(j)) begin
        errors++;
        $display("FAIL areset_resume clk%0d: got %h/%h expected %h/%h",
                 j, act_b, act_s, exp_b(j), exp_s(j));
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 20000; k++) begin
      tick();
      checks++;
      if (act_b !== exp_b(n_b) || act_s !== exp_s(n_s)) begin
        errors++;
        $display("FAIL random n=%0d/%0d: got %h/%h expected %h/%h",
                 n_b, n_s, act_b, act_s, exp_b(n_b), exp_s(n_s));
      end
      sclr_b = ($urandom_range(0, 199) == 0);
      sclr_s = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) begin
        sclr_b = 1'b0;
        sclr_s = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (act_b !== RESET_VEC || act_s !== RESET_VEC) begin
          errors++;
          $display("FAIL random_areset: got %h/%h expected %h", act_b, act_s, RESET_VEC);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end
    sclr_b = 1'b0;
    sclr_s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_sclr();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_640_480.md
# vga_timing_640_480

- Generates the 640x480@60 Hz VGA raster timing from the system clock.
- Provides a pixel-rate enable, horizontal/vertical pixel counters, visible-area enables, sync strobes and the active-low sync pins.
- Sits directly upstream of the pixel colour generator (gen_640_480) and drives its i_px_clk, i_hsync_en, i_vsync_en, i_haddr_en, i_vaddr_en, i_hidx and i_vidx inputs.

## Interface

Parameters:
- DIV, 4, system clocks per pixel (≥2); 100 MHz / 4 = 25 MHz pixel rate
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk, in, 1, system clock. Everything is synchronous to its rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_sclr, in, 1, synchronous clear. Same effect as reset; has priority over counting.
- o_px_clk, out, 1, pixel enable. One-clk pulse every DIV clks. Not a clock.
- o_hsync_en, out, 1, high while the horizontal counter is in the sync region.
- o_vsync_en, out, 1, high while the vertical counter is in the sync region.
- o_haddr_en, out, 1, high while h < H_VISIBLE.
- o_vaddr_en, out, 1, high while v < V_VISIBLE.
- o_hidx, out, 10, h when o_haddr_en is high, else 0.
- o_vidx, out, 9, v[8:0] when o_vaddr_en is high, else 0.
- o_vga_hs, out, 1, ~o_hsync_en (active-low pin).
- o_vga_vs, out, 1, ~o_vsync_en (active-low pin).
- o_frame_start, out, 1, one-clk pulse when o_px_clk=1 and h=0 and v=0.

## Operation

Derived totals:
- H_TOTAL = sum of the H_* parameters = 800.
- V_TOTAL = sum of the V_* parameters = 525.

Registered state:
- div_cnt: 0..DIV-1
- h: 10 bits, 0..H_TOTAL-1
- v: 10 bits, 0..V_TOTAL-1

Divider:
- div_cnt increments every clk and wraps DIV-1 -> 0.
- o_px_clk = (div_cnt == DIV-1).

Horizontal counter:
- Advances only on clk edges where o_px_clk=1.
- h = H_TOTAL-1 -> 0; otherwise h+1.

Vertical counter:
- Advances only on edges where o_px_clk=1 and h = H_TOTAL-1.
- v = V_TOTAL-1 -> 0; otherwise v+1.

Region decode, with boundaries inclusive-exclusive:
- Horizontal sync: [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC) = [656, 752).
- Vertical sync: [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC) = [490, 492).
- Sync, addr and frame outputs are combinational decodes of the registered h/v and need no extra state.
- o_hidx and o_vidx are forced to 0 outside the visible area, so downstream comparisons never see out-of-range indices. v ≥ 512 therefore never truncates into 0..479.

Clear and reset:
- i_sclr=1 at a clk edge loads div_cnt=0, h=0, v=0, regardless of o_px_clk.
- i_rst_n=0 forces the same state immediately, without waiting for a clock.

## Timing

Reset/clear values of the outputs:
- o_px_clk=0
- o_hsync_en=0, o_vsync_en=0
- o_haddr_en=1, o_vaddr_en=1
- o_hidx=0, o_vidx=0
- o_vga_hs=1, o_vga_vs=1
- o_frame_start=0

First cycles after release:
- The first o_px_clk pulse occurs DIV-1 clks after i_rst_n deasserts (or after the i_sclr edge).
- o_frame_start pulses together with that first o_px_clk, because h=v=0.

Latency:
- Every output reflects the current registered counter state in the same cycle.
- h/v change on the clk edge that samples o_px_clk=1. Each pixel index is therefore held for exactly DIV clks.

Rates:
- Line period is H_TOTAL·DIV = 3200 clks.
- Frame period is H_TOTAL·V_TOTAL·DIV = 1,680,000 clks.
- o_hsync_en is high for H_SYNC·DIV = 384 clks per line.
- o_vsync_en is high for V_SYNC full lines = 6400 clks.

Simultaneous events:
- h wrap and v wrap on the same edge both take effect; the next state is h=0, v=0.
- i_sclr together with o_px_clk: the clear wins.

Reset mid-operation:
- Any h/v state is abandoned immediately.
- The counters restart from 0,0 with no partial line or frame completion.

## Test plan

- **Reset and divider:** hold i_rst_n=0, then release.
  - Outputs equal the listed reset values.
  - o_px_clk pulses on clks 3, 7, 11, … (DIV=4).
  - o_hidx reads 0,1,2 in 4-clk steps.
- **Line timing:**
  - o_haddr_en falls at h=640 and o_hidx goes to 0.
  - o_hsync_en rises at h=656 and falls at h=752 (384 clks); o_vga_hs is its inverse.
  - h wraps 799 -> 0 with v incrementing on the same edge.
- **Frame timing:**
  - o_vaddr_en falls at v=480 and o_vidx goes to 0.
  - o_vsync_en is high for lines 490–491 exactly (6400 clks).
  - v=524, h=799 wraps to 0,0.
  - Consecutive o_frame_start pulses are exactly 1,680,000 clks apart.
- **Sync clear:** pulse i_sclr for one clk at h=300, v=200.
  - The next cycle shows h=0, v=0, div_cnt=0.
  - The next o_frame_start arrives 3 clks later.
- **Async reset mid-line:** assert i_rst_n low between clk edges at h=700.
  - Outputs take reset values before the next clk edge.
  - Counting resumes from 0 after release.
- **Downstream pairing:** connect to gen_640_480 and sample the colour at h=150, v=150 and at h=50, v=50.
  - At h=150, v=150 the output is F00.
  - At h=50, v=50 the output is 00F.
  - During blanking the output is 000.
